// File: rtl/vec_ctrl_pkg.sv
// Decode types, control struct and decode helpers shared by the vec_pipe_controller slice.
// Whether SETMASK is legal is decided by the mask_en argument, which the top ties to VEC_MASK_EN.
package vec_ctrl_pkg;

  typedef enum logic [2:0] {
    TYPE_VALU    = 3'b000,
    TYPE_SALU    = 3'b001,
    TYPE_RSV2    = 3'b010,
    TYPE_RSV3    = 3'b011,
    TYPE_VLD     = 3'b100,
    TYPE_VST     = 3'b101,
    TYPE_SETMASK = 3'b110,
    TYPE_NOP     = 3'b111
  } vtype_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  typedef struct packed {
    logic [1:0] reg_src;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic [3:0] alu_op;
    logic       multi_beat;
    logic       set_mask;
  } dec_ctrl_t;

  function automatic logic vec_illegal(input logic [2:0] typ, input logic mask_en);
    logic ill;
    case (typ)
      TYPE_RSV2, TYPE_RSV3: ill = 1'b1;
      TYPE_SETMASK:         ill = ~mask_en;
      default:              ill = 1'b0;
    endcase
    return ill;
  endfunction

  // Illegal and NOP classes decode to an all-zero control word, i.e. a bubble.
  function automatic dec_ctrl_t vec_decode(input logic [2:0] typ, input logic [3:0] op,
                                           input logic mask_en);
    dec_ctrl_t c;
    c = '0;
    case (typ)
      TYPE_VALU: begin
        c.reg_write  = 1'b1;
        c.alu_op     = op;
        c.multi_beat = 1'b1;
      end
      TYPE_SALU: begin
        c.reg_write = 1'b1;
        c.alu_op    = op;
      end
      TYPE_VLD: begin
        c.imm_src    = 2'b01;
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.alu_op     = ALU_ADD;
        c.multi_beat = 1'b1;
      end
      TYPE_VST: begin
        c.reg_src    = 2'b10;
        c.imm_src    = 2'b01;
        c.alu_src    = 1'b1;
        c.mem_write  = 1'b1;
        c.alu_op     = ALU_ADD;
        c.multi_beat = 1'b1;
      end
      TYPE_SETMASK: begin
        c.set_mask = mask_en;
        c.alu_op   = mask_en ? op : ALU_ADD;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vec_beat_seq.sv
// Beat counter for multi-beat vector instructions held in E; produces the Decode stall.
module vec_beat_seq #(
  parameter int BEATS = 4,
  parameter int BW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          multibeat,
  input  logic          flush,
  output logic [BW-1:0] beat,
  output logic          stall
);

  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  logic [BW-1:0] beat_d;
  logic [BW-1:0] beat_q;

  // Stall until the final beat; a flush releases Decode in the same cycle.
  assign stall = multibeat & (beat_q != LAST) & ~flush;
  assign beat  = beat_q;

  // start marks E accepting a new instruction, so the count restarts from zero.
  always_comb begin
    if (flush || start) begin
      beat_d = '0;
    end else begin
      beat_d = beat_q + BW'(1'b1);
    end
  end

  // Beat register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/vec_pipe_controller.sv
// D/E/M/W control unit for the SIMD datapath with lane predication and multi-beat issue.
// Build option VEC_MASK_EN enables the mask register and SETMASK; without it LaneMaskE is all ones.
module vec_pipe_controller
  import vec_ctrl_pkg::*;
#(
  parameter int LANES = 4,
  parameter int VLEN  = 16,
  localparam int BEATS = VLEN / LANES,
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       Type,
  input  logic [3:0]       Op,
  input  logic             FlushE,
  output logic [1:0]       RegSrcD,
  output logic [1:0]       ImmSrcD,
  output logic             IllegalD,
  output logic             StallD,
  output logic             ALUSrcE,
  output logic [3:0]       ALUControlE,
  output logic             MemtoRegE,
  output logic [BW-1:0]    BeatE,
  output logic [LANES-1:0] LaneMaskE,
  output logic [LANES-1:0] MemWriteM,
  output logic [LANES-1:0] RegWriteM,
  output logic [LANES-1:0] RegWriteW,
  output logic             MemtoRegW
);

`ifdef VEC_MASK_EN
  localparam logic MASK_EN = 1'b1;
`else
  localparam logic MASK_EN = 1'b0;
`endif

  dec_ctrl_t        dec_s, e_d, e_q;
  logic             stall_s;
  logic [LANES-1:0] lane_en_s;
  logic [LANES-1:0] regw_m_d, regw_m_q, memw_m_d, memw_m_q, regw_w_d, regw_w_q;
  logic             mtr_m_d, mtr_m_q, mtr_w_d, mtr_w_q;
  logic             unused_s;

  assign dec_s    = vec_decode(Type, Op, MASK_EN);
  assign RegSrcD  = dec_s.reg_src;
  assign ImmSrcD  = dec_s.imm_src;
  assign IllegalD = vec_illegal(Type, MASK_EN);
  assign StallD   = stall_s;

  vec_beat_seq #(.BEATS(BEATS), .BW(BW)) u_beat_seq (
    .clk       (clk),
    .reset     (reset),
    .start     (~stall_s),
    .multibeat (e_q.multi_beat),
    .flush     (FlushE),
    .beat      (BeatE),
    .stall     (stall_s)
  );

  // E register: bubble on flush, hold while beats remain, otherwise take Decode.
  always_comb begin
    e_d = e_q;
    if (FlushE) begin
      e_d = '0;
    end else if (!stall_s) begin
      e_d = dec_s;
    end else begin
      e_d = e_q;
    end
  end

`ifdef VEC_MASK_EN
  logic [LANES-1:0] mask_d, mask_q, pat_s;

  // SETMASK pattern replicates Op every four lanes; a flushed SETMASK leaves the mask alone.
  always_comb begin
    pat_s = '0;
    for (int i = 0; i < LANES; i++) begin
      pat_s[i] = e_q.alu_op[i % 4];
    end
    if (e_q.set_mask && !FlushE) begin
      mask_d = pat_s;
    end else begin
      mask_d = mask_q;
    end
  end

  // Mask register, all lanes active out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '1;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign LaneMaskE = mask_q;
  assign unused_s  = ^{e_q.reg_src, e_q.imm_src};
`else
  assign LaneMaskE = '1;
  assign unused_s  = ^{e_q.reg_src, e_q.imm_src, e_q.set_mask, dec_s.set_mask};
`endif

  // Vector beats use the masked lanes; scalar ops write lane 0 only, unmasked.
  always_comb begin
    if (e_q.multi_beat) begin
      lane_en_s = LaneMaskE;
    end else begin
      lane_en_s = LANES'(1'b1);
    end
    if (FlushE) begin
      regw_m_d = '0;
      memw_m_d = '0;
      mtr_m_d  = 1'b0;
    end else begin
      regw_m_d = e_q.reg_write ? lane_en_s : '0;
      memw_m_d = e_q.mem_write ? lane_en_s : '0;
      mtr_m_d  = e_q.mem_to_reg;
    end
    regw_w_d = regw_m_q;
    mtr_w_d  = mtr_m_q;
  end

  // E/M/W pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q      <= '0;
      regw_m_q <= '0;
      memw_m_q <= '0;
      mtr_m_q  <= 1'b0;
      regw_w_q <= '0;
      mtr_w_q  <= 1'b0;
    end else begin
      e_q      <= e_d;
      regw_m_q <= regw_m_d;
      memw_m_q <= memw_m_d;
      mtr_m_q  <= mtr_m_d;
      regw_w_q <= regw_w_d;
      mtr_w_q  <= mtr_w_d;
    end
  end

  assign ALUSrcE     = e_q.alu_src;
  assign ALUControlE = e_q.alu_op;
  assign MemtoRegE   = e_q.mem_to_reg;
  assign MemWriteM   = memw_m_q;
  assign RegWriteM   = regw_m_q;
  assign RegWriteW   = regw_w_q;
  assign MemtoRegW   = mtr_w_q;

endmodule

// File: tb/tb_vec_pipe_controller.sv
// Directed bench for vec_pipe_controller: a per-cycle schedule of expected outputs is built
// from each issued instruction, then compared against the DUT on every falling edge.
module tb_vec_pipe_controller;

  localparam int LANES = 4;
  localparam int VLEN  = 16;
  localparam int BEATS = 4;
  localparam int N     = 512;
`ifdef VEC_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] Type;
  logic [3:0] Op;
  logic       FlushE;
  logic [1:0] RegSrcD, ImmSrcD, BeatE;
  logic       IllegalD, StallD, ALUSrcE, MemtoRegE, MemtoRegW;
  logic [3:0] ALUControlE, LaneMaskE, MemWriteM, RegWriteM, RegWriteW;

  vec_pipe_controller #(.LANES(LANES), .VLEN(VLEN)) dut (
    .clk(clk), .reset(reset), .Type(Type), .Op(Op), .FlushE(FlushE),
    .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .StallD(StallD),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .MemtoRegE(MemtoRegE), .BeatE(BeatE),
    .LaneMaskE(LaneMaskE), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs indexed by cycle number.
  logic [3:0] x_regw_m [N];
  logic [3:0] x_memw_m [N];
  logic [3:0] x_regw_w [N];
  logic [3:0] x_mask   [N];
  logic [3:0] x_alu    [N];
  logic [1:0] x_beat   [N];
  logic       x_stall  [N];
  logic       x_mtr_w  [N];
  logic       x_mtr_e  [N];
  logic       x_src_e  [N];
  bit         x_alu_v  [N];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int accept = 0;
  int memw_cnt = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void clear_from(input int c);
    for (int i = c; i < N; i++) begin
      x_regw_m[i] = 4'h0; x_memw_m[i] = 4'h0; x_regw_w[i] = 4'h0; x_mask[i] = 4'hF;
      x_alu[i] = 4'h0; x_beat[i] = 2'd0; x_stall[i] = 1'b0; x_mtr_w[i] = 1'b0;
      x_mtr_e[i] = 1'b0; x_src_e[i] = 1'b0; x_alu_v[i] = 1'b0;
    end
  endfunction

  function automatic logic [3:0] mask_pat(input logic [3:0] op);
    logic [3:0] r;
    for (int i = 0; i < LANES; i++) r[i] = op[i % 4];
    return r;
  endfunction

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one instruction in D, schedule everything it must produce, and optionally flush beat fb.
  task automatic issue(input logic [2:0] t, input logic [3:0] op, input int fb);
    int L, n, e;
    logic [3:0] en;
    bit ill, vec, wr_reg, wr_mem, setm;
    L      = (cyc > accept) ? cyc : accept;
    ill    = (t == 3'b010) || (t == 3'b011) || (t == 3'b110 && !MASK_EN);
    vec    = (t == 3'b000) || (t == 3'b100) || (t == 3'b101);
    n      = vec ? BEATS : 1;
    wr_reg = (t == 3'b000) || (t == 3'b001) || (t == 3'b100);
    wr_mem = (t == 3'b101);
    setm   = (t == 3'b110) && MASK_EN;
    for (int k = 0; k < n; k++) begin
      e = L + 1 + k;
      x_beat[e]  = 2'(k);
      x_mtr_e[e] = (t == 3'b100);
      x_src_e[e] = (t == 3'b100) || (t == 3'b101);
      if (t == 3'b000 || t == 3'b001) begin x_alu[e] = op;   x_alu_v[e] = 1'b1; end
      if (t == 3'b100 || t == 3'b101) begin x_alu[e] = 4'h0; x_alu_v[e] = 1'b1; end
      if (fb == k) begin
        x_stall[e] = 1'b0;
        break;
      end
      x_stall[e] = (k < n - 1);
      en = vec ? x_mask[e] : 4'b0001;
      if (wr_reg) begin
        x_regw_m[e + 1] = en;
        x_regw_w[e + 2] = en;
        x_mtr_w[e + 2]  = (t == 3'b100);
      end
      if (wr_mem) x_memw_m[e + 1] = en;
    end
    if (setm && fb != 0) begin
      for (int c = L + 2; c < N; c++) x_mask[c] = mask_pat(op);
    end
    Type = t;
    Op   = op;
    #1;
    check("IllegalD", IllegalD, ill);
    check("RegSrcD", RegSrcD, (t == 3'b101) ? 2'b10 : 2'b00);
    check("ImmSrcD", ImmSrcD, (t == 3'b100 || t == 3'b101) ? 2'b01 : 2'b00);
    while (cyc <= L) begin
      @(posedge clk);
      #1;
    end
    Type = 3'b111;
    Op   = 4'h0;
    if (fb >= 0) begin
      wait_to(L + 1 + fb);
      FlushE = 1'b1;
      @(posedge clk);
      #1;
      FlushE = 1'b0;
      accept = L + 2 + fb;
    end else begin
      accept = L + n;
    end
  endtask

  // Per-cycle comparison against the schedule.
  always @(negedge clk) begin
    if (chk_en && cyc < N) begin
      check("StallD", StallD, x_stall[cyc]);
      check("BeatE", BeatE, x_beat[cyc]);
      check("LaneMaskE", LaneMaskE, x_mask[cyc]);
      check("RegWriteM", RegWriteM, x_regw_m[cyc]);
      check("MemWriteM", MemWriteM, x_memw_m[cyc]);
      check("RegWriteW", RegWriteW, x_regw_w[cyc]);
      check("MemtoRegW", MemtoRegW, x_mtr_w[cyc]);
      check("MemtoRegE", MemtoRegE, x_mtr_e[cyc]);
      check("ALUSrcE", ALUSrcE, x_src_e[cyc]);
      if (x_alu_v[cyc]) check("ALUControlE", ALUControlE, x_alu[cyc]);
    end
    if (MemWriteM != 4'h0) memw_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, c0;
    Type = 3'b111; Op = 4'h0; FlushE = 1'b0; reset = 1'b0;
    clear_from(0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_mask", LaneMaskE, 4'hF);
    check("rst_beat", BeatE, 2'd0);
    check("rst_stall", StallD, 1'b0);
    check("rst_regw_w", RegWriteW, 4'h0);
    check("rst_memw_m", MemWriteM, 4'h0);
    check("rst_alu", ALUControlE, 4'h0);
    reset = 1'b1;
    clear_from(cyc);
    accept = cyc;
    chk_en = 1'b1;

    // Vector ALU: four beats, W writes begin three cycles after issue.
    wait_to(accept); s = cyc;
    issue(3'b000, 4'b0011, -1);
    wait_to(s + 3); check("valu_w_first", RegWriteW, 4'hF);
    wait_to(s + 4); check("valu_beat_last", BeatE, 2'd3); check("valu_stall_last", StallD, 1'b0);
    wait_to(s + 7); check("valu_w_after", RegWriteW, 4'h0);

    // SETMASK then store back to back.
    wait_to(accept); s = cyc;
    issue(3'b110, 4'b0101, -1);
    issue(3'b101, 4'b0000, -1);
    check("store_mask_e", LaneMaskE, MASK_EN ? 4'b0101 : 4'hF);
    wait_to(s + 3);
    check("store_memw_m", MemWriteM, MASK_EN ? 4'b0101 : 4'hF);
    check("store_regw_m", RegWriteM, 4'h0);

    // Scalar ignores the mask.
    wait_to(accept); s = cyc;
    issue(3'b001, 4'h7, -1);
    wait_to(s + 3); check("scalar_w", RegWriteW, 4'b0001);

    // Flush a store at beat 2: two store beats reach M.
    wait_to(accept); s = cyc; c0 = memw_cnt;
    issue(3'b101, 4'h0, 2);
    check("flush_beat_zero", BeatE, 2'd0);
    wait_to(s + 7); check("flush_memw_beats", memw_cnt - c0, 2);

    // Flush coinciding with the last beat, then back-to-back issue across the beat wrap.
    issue(3'b000, 4'h5, 3);
    issue(3'b000, 4'h1, -1);
    issue(3'b110, 4'b0110, -1);
    issue(3'b000, 4'h2, -1);
    issue(3'b100, 4'h0, -1);

    // Illegal classes never write.
    issue(3'b011, 4'hF, -1);
    issue(3'b010, 4'hA, -1);
    issue(3'b110, 4'b1001, -1);
    issue(3'b001, 4'hC, -1);

    // Reset in the middle of a vector op.
    wait_to(accept); s = cyc;
    issue(3'b000, 4'h9, -1);
    wait_to(s + 2);
    chk_en = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("midrst_mask", LaneMaskE, 4'hF);
    check("midrst_beat", BeatE, 2'd0);
    check("midrst_stall", StallD, 1'b0);
    check("midrst_regw_m", RegWriteM, 4'h0);
    check("midrst_memw_m", MemWriteM, 4'h0);
    check("midrst_regw_w", RegWriteW, 4'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    clear_from(cyc);
    accept = cyc;
    chk_en = 1'b1;

    issue(3'b001, 4'h3, -1);
    issue(3'b101, 4'h0, -1);
    wait_to(accept + 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
